pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic parametrised pipeline-stage register. Successor to the hand-written per-stage registers (ID/EX, EX/M, M/WB).
//  Adds a valid/ready handshake, stall backpressure, synchronous flush and an optional 2-entry skid buffer.
//  Side-effect controls (rd_wen, MemWrite, branch, jal, jalr) are carried on a separate ctrl bus.
//  These controls are forced to 0 on bubbles, reset and flush; the data payload is never reset.
// PARAMETERS
//  DATA_W  128  payload width (PC, PC_branch, imm, rs2_rdata, alu_result, addresses ... packed by the instantiating stage)
//  CTRL_W  5    control width; bit map taken from pipe_pkg
//  SKID    1    1: 2-entry skid buffer with registered in_ready; 0: single entry with combinational in_ready
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst_n      in   1       synchronous reset, active-low
//  in_valid   in   1       upstream beat valid
//  in_ready   out  1       stage can accept a beat this cycle
//  in_ctrl    in   CTRL_W  upstream control bits
//  in_data    in   DATA_W  upstream payload
//  flush      in   1       kill all held beats and the beat presented this cycle
//  out_valid  out  1       downstream beat valid
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_ctrl   out  CTRL_W  control bits; all 0 whenever out_valid=0
//  out_data   out  DATA_W  payload; don't-care when out_valid=0
//  count      out  2       entries held: 0..1 when SKID=0, 0..2 when SKID=1
// BEHAVIOUR
//  - Transfer rules: a beat transfers in when in_valid&&in_ready, and out when out_valid&&out_ready.
//  - Reset values: out_valid=0, out_ctrl=0, count=0.
//    - in_ready resets to 0 when SKID=1, then goes to 1 on the first cycle after reset.
//    - Handshakes presented during reset are ignored.
//  - Latency: 1 cycle from input transfer to out_valid when empty. Beat order is strictly preserved (FIFO order).
//  - SKID=0:
//    - in_ready = !out_valid || out_ready (combinational).
//    - Simultaneous output drain and input accept replaces the entry; there is no bubble.
//  - SKID=1 uses entries MAIN (drives the outputs) and SKID. in_ready is registered: in_ready = (count<2) next cycle.
//    - count=0, input accepted -> MAIN loads; count=1.
//    - count=1, input accepted and output taken -> MAIN reloads; count=1.
//    - count=1, input accepted and output stalled -> SKID loads; count=2.
//    - count=1, no input, output taken -> count=0.
//    - count=2, output taken -> MAIN<=SKID; count=1.
//    - count=2: no input transfer is possible because in_ready=0.
//  - Throughput: full rate (1 beat/cycle) while out_ready stays high.
//  - Flush has priority over every other event in the same cycle:
//    - all entries invalidated; held ctrl cleared to 0; count=0 next cycle;
//    - a beat presented in the flush cycle is discarded even if in_ready=1;
//    - an output handshake in the flush cycle still counts as delivered downstream;
//    - in_ready=1 on the next cycle.
//  - Reset mid-stream behaves like flush. in_ready follows the reset rule above.
//  - Stall: while out_valid=1 and out_ready=0, out_ctrl and out_data hold stable (AXI-style rule). out_valid never drops without a handshake or flush.
// STRUCTURE
//  - pipe_pkg:
//    - ctrl bit indices CTRL_RD_WEN=0, CTRL_MEMWRITE=1, CTRL_BRANCH=2, CTRL_JAL=3, CTRL_JALR=4;
//    - CTRL_W_DEF=5;
//    - count encoding localparams.
//  - Sub-module pipe_slot: one storage entry holding valid, ctrl and data.
//    - ctrl and valid are cleared by reset/clear; data is unreset.
//    - The block instantiates one pipe_slot, or two when SKID=1.
//  - Steering FSM in the parent is implicit in count: EMPTY(0) / ONE(1) / FULL(2).
// TESTING
//  - Basic pass, SKID=1: in_data=0xA5 with ctrl=5'b00001, out_ready=1.
//    -> out_valid=1, out_data=0xA5 next cycle; count=1.
//  - Stall fill: out_ready=0 while beats D0, D1 are sent.
//    -> count=2, in_ready=0, out_data=D0 held.
//    -> raise out_ready: D0 then D1 on consecutive cycles; in_ready=1 one cycle after the first drain.
//  - Streaming: 16 back-to-back beats with out_ready=1.
//    -> 16 outputs on 16 consecutive cycles, in order, with no bubbles.
//  - Flush in FULL: count=2, then flush=1 together with in_valid=1.
//    -> next cycle out_valid=0, out_ctrl=0, count=0, in_ready=1; the flush-cycle beat never appears.
//  - Reset mid-stream: rst_n=0 for 1 cycle with count=2.
//    -> out_valid=0, out_ctrl=0 (MemWrite=0) while in reset; normal acceptance resumes one cycle later.
//  - SKID=0 run of the stall/stream cases: in_ready tracks out_ready combinationally.
//    -> count never exceeds 1; ordering is preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: control-bit map and occupancy encoding.
package pipe_pkg;

    localparam int CTRL_RD_WEN   = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_JAL      = 3;
    localparam int CTRL_JALR     = 4;
    localparam int CTRL_W_DEF    = 5;

    // Occupancy of a stage; doubles as the steering state of the skid variant.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: valid and ctrl are cleared by reset/clear,
// the payload is left unreset so it costs no reset fan-out.
module pipe_slot #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Clear wins over load so a killed beat never leaves side-effect bits behind.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush and an optional
// 2-entry skid buffer that breaks the combinational ready path.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              acc;
    logic              take;
    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    assign acc  = in_valid && in_ready;
    assign take = main_valid && out_ready;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (main_clr),
        .load_i  (main_load),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    if (SKID) begin : g_skid
        logic              skid_load;
        logic              skid_clr;
        logic              main_from_skid;
        logic              skid_valid;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;
        cnt_e              count_d;
        cnt_e              count_q;
        logic              in_ready_q;

        pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (skid_clr),
            .load_i  (skid_load),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .valid_o (skid_valid),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
        );

        always_comb begin
            main_load      = 1'b0;
            main_clr       = 1'b0;
            skid_load      = 1'b0;
            skid_clr       = 1'b0;
            main_from_skid = 1'b0;
            count_d        = count_q;
            case (count_q)
                CNT_EMPTY: begin
                    if (acc) begin
                        main_load = 1'b1;
                        count_d   = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (acc && take) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        skid_load = 1'b1;
                        count_d   = CNT_FULL;
                    end else if (take) begin
                        main_clr = 1'b1;
                        count_d  = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (take) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        count_d        = CNT_ONE;
                    end
                end
                default: count_d = CNT_EMPTY;
            endcase
            // Flush overrides every handshake decided above.
            if (flush) begin
                main_load = 1'b0;
                skid_load = 1'b0;
                main_clr  = 1'b1;
                skid_clr  = 1'b1;
                count_d   = CNT_EMPTY;
            end
        end

        assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
        assign main_data_d = main_from_skid ? skid_data : in_data;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                count_q    <= CNT_EMPTY;
                in_ready_q <= 1'b0;
            end else begin
                count_q    <= count_d;
                in_ready_q <= (count_d != CNT_FULL);
            end
        end

        assign in_ready = in_ready_q;
        assign count    = count_q;

        logic unused_skid;
        assign unused_skid = skid_valid;
    end else begin : g_single
        // Drain and refill in the same cycle simply overwrites the entry.
        assign in_ready    = !main_valid || out_ready;
        assign main_load   = acc && !flush;
        assign main_clr    = flush || (take && !acc);
        assign main_ctrl_d = in_ctrl;
        assign main_data_d = in_data;
        assign count       = {1'b0, main_valid};
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: both SKID variants driven by the same stimulus and compared
// every cycle against queue-based reference models.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = CTRL_W_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          rdy1, ov1, rdy0, ov0;
    logic [CW-1:0] oc1, oc0;
    logic [DW-1:0] od1, od0;
    logic [1:0]    cnt1, cnt0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov1),
        .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1), .count(cnt1)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov0),
        .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0), .count(cnt0)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t q1[$];
    beat_t q0[$];
    logic  rdy1_m;
    int    n_chk;
    int    n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("s1.out_valid", 64'(ov1), 64'(q1.size() != 0));
        chk("s1.count", 64'(cnt1), 64'(q1.size()));
        chk("s1.in_ready", 64'(rdy1), 64'(rdy1_m));
        chk("s1.out_ctrl", 64'(oc1), (q1.size() != 0) ? 64'(q1[0].c) : 64'd0);
        if (q1.size() != 0) chk("s1.out_data", 64'(od1), 64'(q1[0].d));
        chk("s0.out_valid", 64'(ov0), 64'(q0.size() != 0));
        chk("s0.count", 64'(cnt0), 64'(q0.size()));
        chk("s0.in_ready", 64'(rdy0), 64'((q0.size() == 0) || out_ready));
        chk("s0.out_ctrl", 64'(oc0), (q0.size() != 0) ? 64'(q0[0].c) : 64'd0);
        if (q0.size() != 0) chk("s0.out_data", 64'(od0), 64'(q0[0].d));
    endtask

    // Called at a negedge: apply inputs, advance the models across the next posedge, check.
    task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic f, input logic ordy, input logic rn);
        logic  acc1, take1, acc0, take0;
        beat_t b;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        rst_n     = rn;
        b.c = c;
        b.d = d;
        acc1  = v && rdy1_m;
        take1 = (q1.size() != 0) && ordy;
        acc0  = v && ((q0.size() == 0) || ordy);
        take0 = (q0.size() != 0) && ordy;
        if (!rn || f) begin
            q1.delete();
            q0.delete();
        end else begin
            if (take1) void'(q1.pop_front());
            if (acc1) q1.push_back(b);
            if (take0) void'(q0.pop_front());
            if (acc0) q0.push_back(b);
        end
        rdy1_m = rn && (q1.size() < 2);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, ordy, 1'b1);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rdy1_m = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset, with a handshake offered that must be ignored
        cycle(1'b1, 5'b11111, 32'h1111, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("rst.in_ready1", 64'(rdy1), 64'd0);
        chk("rst.out_valid1", 64'(ov1), 64'd0);
        idle(1'b1);
        chk("post_rst.in_ready1", 64'(rdy1), 64'd1);

        // Basic pass
        cycle(1'b1, 5'b00001, 32'hA5, 1'b0, 1'b1, 1'b1);
        chk("basic.out_valid", 64'(ov1), 64'd1);
        chk("basic.out_data", 64'(od1), 64'hA5);
        chk("basic.out_ctrl", 64'(oc1), 64'd1);
        idle(1'b1);

        // Stall fill then drain
        cycle(1'b1, 5'b00100, 32'hD0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 5'b01000, 32'hD1, 1'b0, 1'b0, 1'b1);
        chk("fill.count", 64'(cnt1), 64'd2);
        chk("fill.in_ready", 64'(rdy1), 64'd0);
        idle(1'b0);
        chk("fill.hold_data", 64'(od1), 64'hD0);
        idle(1'b1);
        chk("drain.second", 64'(od1), 64'hD1);
        chk("drain.in_ready", 64'(rdy1), 64'd1);
        idle(1'b1);

        // Streaming: out_valid must stay high with consecutive payloads
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, CW'($urandom_range(0, 31)), DW'(32'h100 + i), 1'b0, 1'b1, 1'b1);
            chk("stream.data", 64'(od1), 64'(32'h100 + i));
        end
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a beat offered in the flush cycle
        cycle(1'b1, 5'b10000, 32'hE0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 5'b10000, 32'hE1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 5'b11111, 32'hDEAD, 1'b1, 1'b0, 1'b1);
        chk("flush.out_valid", 64'(ov1), 64'd0);
        chk("flush.out_ctrl", 64'(oc1), 64'd0);
        chk("flush.count", 64'(cnt1), 64'd0);
        chk("flush.in_ready", 64'(rdy1), 64'd1);
        idle(1'b1);

        // Reset mid-stream while full of MemWrite beats
        cycle(1'b1, CW'(1 << CTRL_MEMWRITE), 32'hF0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, CW'(1 << CTRL_MEMWRITE), 32'hF1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("midrst.out_valid", 64'(ov1), 64'd0);
        chk("midrst.memwrite", 64'(oc1[CTRL_MEMWRITE]), 64'd0);
        cycle(1'b1, 5'b00011, 32'hF2, 1'b0, 1'b1, 1'b1);
        chk("midrst.ready_late", 64'(rdy1), 64'd1);
        cycle(1'b1, 5'b00011, 32'hF3, 1'b0, 1'b1, 1'b1);
        chk("midrst.accept", 64'(od1), 64'hF3);
        idle(1'b1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, CW'($urandom()), DW'($urandom()),
                  $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 127) != 0);
            chk("s0.count_le1", 64'(cnt0 <= 2'd1), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
